// File: rtl/viterbi_pkg.sv
// Shared types for the Viterbi sentence controller: FSM state encoding, default sizes
// and the bundle of datapath control pins.
package viterbi_pkg;

  localparam int unsigned PosNumDefault  = 11;
  localparam int unsigned WordNumDefault = 16;

  typedef enum logic [3:0] {
    StIdle,
    StEmiss,
    StLatch,
    StNextw,
    StTrans,
    StMaxsel,
    StPush,
    StPop,
    StDone,
    StErr
  } vctrl_state_t;

  typedef struct packed {
    logic increment_enable_Words_control;
    logic increment_enable_Emiss_control;
    logic increment_enable_Transition_control;
    logic RW_Key_reg;
    logic decrement_enable;
    logic RW_Pre_addr_encode;
    logic RW_Pre_Posibility;
    logic S_key_0;
    logic S_key_1;
    logic S_POS_HMM_0;
    logic S_POS_HMM_1;
    logic S_POS_HMM_2;
    logic S_posibility_0;
    logic S_posibility_1;
    logic RW_HMM_matrix;
    logic change_enable;
    logic choose_output;
    logic RW_Max_posibility;
    logic RW_Stack_POS;
    logic reset_Stack_POS;
  } dp_ctrl_t;

  // States in which a datapath error (or watchdog) aborts the sentence.
  function automatic logic is_active(vctrl_state_t s);
    return s inside {StEmiss, StLatch, StNextw, StTrans, StMaxsel, StPush, StPop};
  endfunction

endpackage

// File: rtl/viterbi_controller_if.sv
// Host handshake, datapath status/control and POS output stream of the Viterbi controller.
interface viterbi_controller_if #(
  parameter int unsigned POS_num_bit = 4
);
  import viterbi_pkg::*;

  // Host side
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   err;
  // Datapath status
  logic [POS_num_bit-1:0] i;
  logic [POS_num_bit-1:0] j;
  logic                   endline;
  logic                   error;
  logic                   stack_empty;
  logic [POS_num_bit-1:0] final_POS;
  // Datapath control
  dp_ctrl_t               ctrl;
  // POS stream
  logic [POS_num_bit-1:0] pos_out;
  logic                   pos_valid;
  logic                   pos_ready;

  modport slave (
    input  start, i, j, endline, error, stack_empty, final_POS, pos_ready,
    output busy, done, err, ctrl, pos_out, pos_valid
  );

  modport master (
    output start, i, j, endline, error, stack_empty, final_POS, pos_ready,
    input  busy, done, err, ctrl, pos_out, pos_valid
  );

endinterface

// File: rtl/viterbi_ctrl_decode.sv
// Moore decoder from controller state to the datapath control vector.
module viterbi_ctrl_decode
  import viterbi_pkg::*;
(
  input  vctrl_state_t state_i,
  output dp_ctrl_t     ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    // Active-low stack clear: held in clear only while idle.
    ctrl_o.reset_Stack_POS = (state_i != StIdle);
    unique case (state_i)
      StEmiss: begin
        ctrl_o.increment_enable_Emiss_control = 1'b1;
        ctrl_o.RW_Key_reg                     = 1'b1;
        ctrl_o.S_key_1                        = 1'b1;
        ctrl_o.S_POS_HMM_0                    = 1'b1;
        ctrl_o.S_posibility_1                 = 1'b1;
        ctrl_o.RW_HMM_matrix                  = 1'b1;
      end
      StLatch: begin
        ctrl_o.RW_Pre_Posibility  = 1'b1;
        ctrl_o.RW_Pre_addr_encode = 1'b1;
        ctrl_o.choose_output      = 1'b1;
        ctrl_o.RW_Key_reg         = 1'b1;
      end
      StNextw: begin
        ctrl_o.increment_enable_Words_control = 1'b1;
        ctrl_o.RW_Key_reg                     = 1'b1;
      end
      StTrans: begin
        ctrl_o.increment_enable_Transition_control = 1'b1;
        ctrl_o.RW_Key_reg                          = 1'b1;
        ctrl_o.S_key_1                             = 1'b1;
        ctrl_o.S_POS_HMM_0                         = 1'b1;
        ctrl_o.S_posibility_0                      = 1'b1;
        ctrl_o.RW_HMM_matrix                       = 1'b1;
      end
      StMaxsel: begin
        ctrl_o.RW_Max_posibility = 1'b1;
        ctrl_o.change_enable     = 1'b1;
      end
      StPush: begin
        ctrl_o.RW_Stack_POS     = 1'b1;
        ctrl_o.decrement_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/viterbi_controller.sv
// Sentence-level Viterbi sequencing FSM. Define VITERBI_CTRL_WATCHDOG_EN to build a
// per-state 12-bit watchdog that aborts a stuck sentence as if the datapath flagged error.
module viterbi_controller
  import viterbi_pkg::*;
#(
  parameter int unsigned word_num     = WordNumDefault,
  parameter int unsigned word_num_bit = 4,
  parameter int unsigned POS_num      = PosNumDefault,
  parameter int unsigned POS_num_bit  = 4
) (
  input logic           clk,
  input logic           reset,
  viterbi_controller_if.slave bus_io
);

  localparam int unsigned WcntW = word_num_bit + 1;
  localparam int unsigned PosW  = $clog2(POS_num + 1);
  localparam int unsigned CntW  = (WcntW > PosW) ? WcntW : PosW;

  localparam logic [POS_num_bit-1:0] PosLast = POS_num_bit'(POS_num - 1);
  localparam logic [WcntW-1:0]       WordMax = WcntW'(word_num);
  localparam logic [CntW-1:0]        SelLast = CntW'(POS_num - 1);

  vctrl_state_t     state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wd_trip;
  logic             fault;
  dp_ctrl_t         dec_ctrl;
  logic             in_pop;
  logic             pop_fire;

`ifdef VITERBI_CTRL_WATCHDOG_EN
  logic [11:0] wd_q, wd_d;

  assign wd_trip = (wd_q == 12'hfff);

  always_comb begin
    wd_d = wd_q + 12'd1;
    if (state_d != state_q || state_q == StIdle) begin
      wd_d = '0;
    end else if (wd_trip) begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  assign fault = is_active(state_q) && (bus_io.error || wd_trip);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StEmiss;
          wcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      StEmiss: if (bus_io.i == PosLast) state_d = StLatch;
      StLatch: begin
        if (wcnt_q != WordMax) wcnt_d = wcnt_q + 1'b1;
        state_d = StNextw;
      end
      StNextw: state_d = (bus_io.endline || wcnt_q == WordMax) ? StMaxsel : StTrans;
      StTrans: if (bus_io.i == PosLast && bus_io.j == PosLast) state_d = StLatch;
      StMaxsel: begin
        if (cnt_q == SelLast) begin
          cnt_d   = '0;
          state_d = StPush;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPush: begin
        // One push per latched word.
        if ((cnt_q + 1'b1) >= CntW'(wcnt_q)) begin
          cnt_d   = '0;
          state_d = StPop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPop:   if (bus_io.stack_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (fault) begin
      state_d = StErr;
      cnt_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  viterbi_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (dec_ctrl)
  );

  assign in_pop   = (state_q == StPop);
  assign pop_fire = bus_io.pos_valid && bus_io.pos_ready;

  always_comb begin
    bus_io.ctrl               = dec_ctrl;
    bus_io.ctrl.choose_output = dec_ctrl.choose_output | pop_fire;
  end

  assign bus_io.pos_valid = in_pop && !bus_io.stack_empty;
  assign bus_io.pos_out   = in_pop ? bus_io.final_POS : '0;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = (state_q == StDone) || (state_q == StErr);
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_viterbi_controller.sv
// Randomized bench: a behavioural datapath/stack model drives the controller and a
// phase schedule derived from sentence length predicts every cycle's control vector.
module tb_viterbi_controller;
  import viterbi_pkg::*;

  localparam int PN = 11;
  localparam int WN = 16;

  typedef enum int {PhIdle, PhEmiss, PhLatch, PhNextw, PhTrans, PhMaxsel, PhPush, PhPop,
                    PhDone, PhErr} phase_e;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  viterbi_controller_if #(.POS_num_bit(4)) bus ();

  viterbi_controller #(
    .word_num     (WN),
    .word_num_bit (4),
    .POS_num      (PN),
    .POS_num_bit  (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int   vectors;
  int   miscompares;
  int   stk[$];
  int   mi, mj, widx, n_target;
  bit   freeze_i;
  logic rdy;

  function automatic dp_ctrl_t phase_ctrl(phase_e ph);
    dp_ctrl_t c;
    c = '0;
    c.reset_Stack_POS = (ph != PhIdle);
    case (ph)
      PhEmiss: begin
        c.increment_enable_Emiss_control = 1; c.RW_Key_reg = 1; c.S_key_1 = 1;
        c.S_POS_HMM_0 = 1; c.S_posibility_1 = 1; c.RW_HMM_matrix = 1;
      end
      PhLatch: begin
        c.RW_Pre_Posibility = 1; c.RW_Pre_addr_encode = 1; c.choose_output = 1;
        c.RW_Key_reg = 1;
      end
      PhNextw: begin c.increment_enable_Words_control = 1; c.RW_Key_reg = 1; end
      PhTrans: begin
        c.increment_enable_Transition_control = 1; c.RW_Key_reg = 1; c.S_key_1 = 1;
        c.S_POS_HMM_0 = 1; c.S_posibility_0 = 1; c.RW_HMM_matrix = 1;
      end
      PhMaxsel: begin c.RW_Max_posibility = 1; c.change_enable = 1; end
      PhPush:   begin c.RW_Stack_POS = 1; c.decrement_enable = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic drive_dp();
    bus.i           = freeze_i ? 4'd0 : 4'(mi);
    bus.j           = 4'(mj);
    bus.endline     = (widx == n_target - 1);
    bus.stack_empty = (stk.size() == 0);
    bus.final_POS   = (stk.size() > 0) ? 4'(stk[$]) : 4'd0;
    bus.pos_ready   = rdy;
  endtask

  task automatic clear_model();
    stk.delete();
    mi = 0; mj = 0; widx = 0;
  endtask

  // Datapath model reacts to this cycle's controls, then the clock advances.
  task automatic dp_step();
    dp_ctrl_t c;
    c = bus.ctrl;
    if (!c.reset_Stack_POS) begin
      clear_model();
    end else begin
      if (c.increment_enable_Emiss_control) mi = (mi == PN - 1) ? 0 : mi + 1;
      if (c.increment_enable_Transition_control) begin
        if (mj == PN - 1) begin
          mj = 0;
          mi = (mi == PN - 1) ? 0 : mi + 1;
        end else begin
          mj = mj + 1;
        end
      end
      if (c.increment_enable_Words_control) widx = widx + 1;
      if (c.RW_Stack_POS) stk.push_back(int'($urandom_range(0, PN - 1)));
      else if (c.choose_output && stk.size() > 0) void'(stk.pop_back());
    end
    @(posedge clk);
    #1;
    drive_dp();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.error = 1'b0; rdy = 1'b1; freeze_i = 1'b0;
    clear_model();
    drive_dp();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ctrl !== '0 || bus.busy !== 0 || bus.done !== 0 || bus.err !== 0) begin
      miscompares++;
      $display("FAIL reset_flags: ctrl=%h busy=%b done=%b err=%b, want all 0",
               bus.ctrl, bus.busy, bus.done, bus.err);
    end
    vectors++;
    if (bus.pos_valid !== 0 || bus.pos_out !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_stream: pos_valid=%b pos_out=%h, want 0/0", bus.pos_valid,
               bus.pos_out);
    end
    do_reset();
  endtask

  // n words (n > WN never raises endline), stall: ready low for first POP cycles,
  // negative = random ready; spam holds start high while busy.
  task automatic test_sentence(input int n, input int stall, input bit spam);
    phase_e sched[$];
    int eff, popc, guard;
    dp_ctrl_t ec;
    logic applied;
    eff = (n > WN) ? WN : n;
    n_target = n;
    repeat (PN) sched.push_back(PhEmiss);
    sched.push_back(PhLatch); sched.push_back(PhNextw);
    for (int w = 1; w < eff; w++) begin
      repeat (PN * PN) sched.push_back(PhTrans);
      sched.push_back(PhLatch); sched.push_back(PhNextw);
    end
    repeat (PN) sched.push_back(PhMaxsel);
    repeat (eff) sched.push_back(PhPush);
    rdy = (stall == 0);
    bus.start = 1'b1;
    dp_step();
    bus.start = spam;
    vectors++;
    if (bus.err !== 0) begin
      miscompares++;
      $display("FAIL first_emiss_err: err=%b, want 0", bus.err);
    end
    foreach (sched[k]) begin
      vectors++;
      if (bus.ctrl !== phase_ctrl(sched[k]) || bus.busy !== 1 || bus.done !== 0 ||
          bus.pos_valid !== 0) begin
        miscompares++;
        $display("FAIL n%0d_cycle%0d_%s: ctrl=%h busy=%b done=%b pv=%b, want ctrl=%h 1/0/0",
                 n, k, sched[k].name(), bus.ctrl, bus.busy, bus.done, bus.pos_valid,
                 phase_ctrl(sched[k]));
      end
      if (stall < 0) rdy = 1'($urandom_range(0, 1));
      dp_step();
    end
    popc = 0;
    guard = 0;
    while (stk.size() > 0 && guard < 200) begin
      applied = rdy;
      ec = phase_ctrl(PhPop);
      ec.choose_output = applied;
      vectors++;
      if (bus.pos_valid !== 1 || bus.pos_out !== 4'(stk[$]) || bus.ctrl !== ec ||
          bus.busy !== 1 || bus.done !== 0) begin
        miscompares++;
        $display("FAIL n%0d_pop%0d: pv=%b pos=%h ctrl=%h done=%b, want pv=1 pos=%h ctrl=%h",
                 n, popc, bus.pos_valid, bus.pos_out, bus.ctrl, bus.done, 4'(stk[$]), ec);
      end
      popc++;
      rdy = (stall < 0) ? 1'($urandom_range(0, 1)) : (popc >= stall);
      dp_step();
      guard++;
    end
    vectors++;
    if (stk.size() > 0) begin
      miscompares++;
      $display("FAIL n%0d_pop_timeout: %0d entries left, want 0", n, stk.size());
    end
    vectors++;
    if (bus.pos_valid !== 0 || bus.ctrl !== phase_ctrl(PhPop) || bus.busy !== 1) begin
      miscompares++;
      $display("FAIL n%0d_pop_empty: pv=%b ctrl=%h busy=%b, want 0 %h 1", n,
               bus.pos_valid, bus.ctrl, bus.busy, phase_ctrl(PhPop));
    end
    dp_step();
    vectors++;
    if (bus.done !== 1 || bus.busy !== 1 || bus.err !== 0 || bus.ctrl !== phase_ctrl(PhDone))
    begin
      miscompares++;
      $display("FAIL n%0d_done: done=%b busy=%b err=%b ctrl=%h, want 1 1 0 %h", n, bus.done,
               bus.busy, bus.err, bus.ctrl, phase_ctrl(PhDone));
    end
    dp_step();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.ctrl !== '0) begin
      miscompares++;
      $display("FAIL n%0d_idle: busy=%b done=%b ctrl=%h, want 0 0 0", n, bus.busy, bus.done,
               bus.ctrl);
    end
  endtask

  task automatic test_error();
    n_target = 3;
    bus.start = 1'b1;
    dp_step();
    bus.start = 1'b0;
    repeat (3) dp_step();
    bus.error = 1'b1;
    dp_step();
    bus.error = 1'b0;
    vectors++;
    if (bus.done !== 1 || bus.err !== 1 || bus.busy !== 1 || bus.ctrl !== phase_ctrl(PhErr))
    begin
      miscompares++;
      $display("FAIL err_state: done=%b err=%b busy=%b ctrl=%h, want 1 1 1 %h", bus.done,
               bus.err, bus.busy, bus.ctrl, phase_ctrl(PhErr));
    end
    repeat (3) dp_step();
    vectors++;
    if (bus.done !== 0 || bus.err !== 1 || bus.busy !== 0) begin
      miscompares++;
      $display("FAIL err_sticky: done=%b err=%b busy=%b, want 0 1 0", bus.done, bus.err,
               bus.busy);
    end
    bus.start = 1'b1;
    dp_step();
    bus.start = 1'b0;
    vectors++;
    if (bus.err !== 0 || bus.busy !== 1 || bus.ctrl !== phase_ctrl(PhEmiss)) begin
      miscompares++;
      $display("FAIL err_clear: err=%b busy=%b ctrl=%h, want 0 1 %h", bus.err, bus.busy,
               bus.ctrl, phase_ctrl(PhEmiss));
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    n_target = 3;
    bus.start = 1'b1;
    dp_step();
    bus.start = 1'b0;
    repeat (33) dp_step();
    vectors++;
    if (bus.ctrl !== phase_ctrl(PhTrans)) begin
      miscompares++;
      $display("FAIL mid_in_trans: ctrl=%h, want %h", bus.ctrl, phase_ctrl(PhTrans));
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ctrl !== '0 || bus.busy !== 0 || bus.done !== 0 || bus.pos_valid !== 0 ||
        bus.err !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_async: ctrl=%h busy=%b done=%b pv=%b err=%b, want all 0",
               bus.ctrl, bus.busy, bus.done, bus.pos_valid, bus.err);
    end
    clear_model();
    drive_dp();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #2;
      vectors++;
      if (bus.done !== 0 || bus.busy !== 0) begin
        miscompares++;
        $display("FAIL mid_reset_hold%0d: done=%b busy=%b, want 0 0", k, bus.done, bus.busy);
      end
    end
    reset = 1'b0;
    dp_step();
    vectors++;
    if (bus.done !== 0 || bus.busy !== 0 || bus.ctrl !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_after: done=%b busy=%b ctrl=%h, want 0 0 0", bus.done,
               bus.busy, bus.ctrl);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    n_target = 1;
    freeze_i = 1'b1;
    bus.start = 1'b1;
    dp_step();
    bus.start = 1'b0;
    while (cyc < 4200 && !seen) begin
      if (bus.done === 1) seen = 1;
      else begin
        dp_step();
        cyc++;
      end
    end
    vectors++;
`ifdef VITERBI_CTRL_WATCHDOG_EN
    if (!seen || bus.err !== 1 || cyc < 4090 || cyc > 4100) begin
      miscompares++;
      $display("FAIL watchdog_trip: seen=%0d err=%b cycles=%0d, want abort near 4096",
               seen, bus.err, cyc);
    end
`else
    if (seen || bus.busy !== 1 || bus.ctrl !== phase_ctrl(PhEmiss)) begin
      miscompares++;
      $display("FAIL stuck_emiss: done_seen=%0d busy=%b ctrl=%h, want 0 1 %h", seen,
               bus.busy, bus.ctrl, phase_ctrl(PhEmiss));
    end
`endif
    do_reset();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_target = 1;
    bus.start = 1'b0; bus.error = 1'b0; rdy = 1'b1; freeze_i = 1'b0;
    clear_model();
    drive_dp();
    test_reset();
    test_sentence(1, 0, 1'b0);
    test_sentence(3, 0, 1'b0);
    test_sentence(3, 5, 1'b0);
    // Back to back, with start held high while busy to show it is dropped.
    test_sentence(2, -1, 1'b1);
    test_sentence(1, -1, 1'b0);
    test_sentence(20, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      test_sentence(int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)));
    end
    test_error();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
